ra_site_ctl: RTL and testbench
==============================

RA_SITE_CTL -- requirements
Module: ra_site_ctl

Interface
REQ-001 Parameter NRA, default 2: number of attached register arrays, legal 1..8.
REQ-002 Parameter AW, default 5: array word-address width.
REQ-003 Parameter DW, default 32: array data width, multiple of 8, legal 8..32.
REQ-004 Parameter RLAT, default 1: array read latency in cycles from enb to valid data, legal 1..4.
REQ-005 Ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_val  in  1  command valid.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  byte address.
- cmd_sel  in  4  byte-lane enables.
- cmd_dat  in  32  write data.
- rd_ack  out  1  one-cycle completion pulse, one per accepted command.
- rd_dat  out  32  read data, valid with rd_ack.
- busy  out  1  command in flight; cmd_val ignored while high.
- err  out  3  sticky error flags.
- ra_r0_enb / ra_r1_enb  out  NRA  per-array read-port enables.
- ra_r0_adr / ra_r1_adr  out  NRA*AW  per-array read addresses.
- ra_r0_dat / ra_r1_dat  in  NRA*DW  per-array read data.
- ra_w0_enb  out  NRA  per-array write enable.
- ra_w0_adr  out  NRA*AW  write address.
- ra_w0_dat  out  NRA*DW  write data.

Function
REQ-006 Address decode: word = cmd_adr[AW+1:2]; array index = cmd_adr[AW+4:AW+2]; read port = cmd_adr[AW+5] (0=r0, 1=r1).
REQ-007 FSM states IDLE, RD, RMW_RD, WR, RB (RB only with RA_READBACK_EN), ACK; busy=1 in every state except IDLE.
REQ-008 Accept: in IDLE, cmd_val=1 at cycle T captures all cmd fields; accepted cycle is T.
REQ-009 Read: selected port enb high for exactly one cycle at T+1; data sampled at T+1+RLAT; rd_ack with rd_dat = zero-extended DW data at T+2+RLAT.
REQ-010 Full write (cmd_sel covers all DW/8 lanes): ra_w0_enb high one cycle at T+1 with cmd_dat[DW-1:0]; rd_ack at T+2, rd_dat=0.
REQ-011 Partial write (nonzero cmd_sel not covering all lanes): r0 read at T+1, sample at T+1+RLAT, write at T+2+RLAT of old data merged per byte with cmd_dat under cmd_sel, rd_ack at T+3+RLAT.
REQ-012 Write with cmd_sel lanes all zero within DW: no array access; rd_ack at T+2.
REQ-013 Array index >= NRA: no array access; err[0] set; reads return rd_dat=32'hFFFFFFFF; rd_ack at T+2.
REQ-014 cmd_val=1 while busy=1: command dropped, err[1] set, no ack.
REQ-015 Only the indexed array's enb bits toggle; all enb outputs 0 outside their access cycle.
REQ-016 Address/data outputs of non-selected arrays hold 0.
REQ-017 err bits sticky until rst; set and ack in the same cycle allowed.

Reset
REQ-018 rst=1 forces IDLE, busy=0, rd_ack=0, rd_dat=0, err=0, every enb/adr/dat output 0 on the next edge.
REQ-019 rst mid-command discards it: no ack, no further array access, even if write was pending.

Configuration
REQ-020 Macro RA_READBACK_EN defined: after every array write at cycle W, r1 read of the same address at W+1, compare at W+1+RLAT, mismatch sets err[2]; rd_ack moves to W+2+RLAT.
REQ-021 RA_READBACK_EN undefined: RB state and compare logic absent, err[2] tied 0, write timing per REQ-010/011.

Structure
REQ-022 Package ra_site_pkg holds state enum, err bit indices (ERR_SEL=0, ERR_DROP=1, ERR_RB=2), address field offsets, BAD_RD_DAT=32'hFFFFFFFF.
REQ-023 One sub-module ra_rlat_pipe: RLAT-deep valid shift register producing the data-sample strobe; instantiated once.

Verification (NRA=2, AW=5, DW=32, RLAT=1 unless stated)
REQ-024 Write adr 0x0C data 0xA5A5A5A5 sel 0xF, then read adr 0x0C -> ra_w0_enb[0] at T+1, write ack at T+2; read ack at T+3 with rd_dat 0xA5A5A5A5.
REQ-025 Word 3 holds 0x11223344; write sel 0x2 data 0x0000BB00 -> ra_w0_dat 0x1122BB44 at T+3, ack T+4.
REQ-026 Read adr 0x100 (array 2, NRA=2) -> no enb, ack T+2 rd_dat 0xFFFFFFFF, err=3'b001.
REQ-027 cmd_val at T and T+1 -> second dropped, err[1]=1, exactly one rd_ack; rst at T+1 of a read -> no ack, busy=0, outputs 0.
REQ-028 RLAT=3, r1 read (adr bit 10 set) of array 1 -> ra_r1_enb[1] at T+1, ack T+5.
REQ-029 RA_READBACK_EN with array model corrupting bit 0 -> err[2]=1, ack at W+3; correct model -> err[2]=0.

Source files
------------

// File: rtl/ra_site_pkg.sv
// ----------------------------------------------------------------------------
// ra_site_pkg
// Shared definitions for the register-array site controller: the FSM state
// encoding, error flag bit positions, command address field layout and the
// data pattern returned for reads that address a missing array.
// Optional feature macro: RA_READBACK_EN (adds the S_RB readback state).
// ----------------------------------------------------------------------------
package ra_site_pkg;

`ifdef RA_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RB     = 3'd4,
    S_ACK    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_ACK    = 3'd5
  } state_t;
`endif

  // Sticky error flag bit positions
  localparam int ERR_SEL  = 0;  // array index beyond NRA
  localparam int ERR_DROP = 1;  // command presented while busy
  localparam int ERR_RB   = 2;  // readback compare mismatch
  localparam int ERR_W    = 3;

  // Command address layout: [port][index][word][byte]
  localparam int WORD_LSB = 2;
  localparam int IDX_W    = 3;

  localparam logic [31:0] BAD_RD_DAT = 32'hFFFF_FFFF;

  function automatic int idx_lsb(input int aw);
    return aw + WORD_LSB;
  endfunction

  function automatic int port_bit(input int aw);
    return aw + WORD_LSB + IDX_W;
  endfunction

endpackage

// File: rtl/ra_rlat_pipe.sv
// ----------------------------------------------------------------------------
// ra_rlat_pipe
// RLAT-deep valid shift register. A one-cycle read-enable strobe entering on
// vld_p0 emerges on smp exactly RLAT cycles later, marking the cycle in which
// the array read data is valid and should be sampled.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset (clears all stages)
//   vld_p0 in  read-enable strobe issued to the array
//   smp    out data-sample strobe
// ----------------------------------------------------------------------------
module ra_rlat_pipe
  import ra_site_pkg::*;
#(
  parameter int RLAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_p0,
  output logic smp
);

  logic [RLAT-1:0] vld_sr;

  generate
    if (RLAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= vld_p0;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst) vld_sr <= '0;
        else     vld_sr <= {vld_sr[RLAT-2:0], vld_p0};
      end
    end
  endgenerate

  assign smp = vld_sr[RLAT-1];

endmodule

// File: rtl/ra_site_ctl.sv
// ----------------------------------------------------------------------------
// ra_site_ctl
// Single-command controller in front of NRA register arrays, each with two
// read ports (r0, r1) and one write port (w0). Reads, full writes and
// byte-masked read-modify-write cycles are sequenced by a small FSM; every
// accepted command ends with one rd_ack pulse.
// Optional feature macro: RA_READBACK_EN -- after every array write the
// word is re-read through r1 and compared; a mismatch sets err[2].
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_val/we/adr/sel/dat   command (accepted only while busy=0)
//   rd_ack, rd_dat           completion pulse and read data
//   busy                     command in flight
//   err[2:0]                 sticky flags {readback, drop, bad index}
//   ra_r0_*/ra_r1_*          per-array read ports (enb, adr out; dat in)
//   ra_w0_*                  per-array write port
// ----------------------------------------------------------------------------
module ra_site_ctl
  import ra_site_pkg::*;
#(
  parameter int NRA  = 2,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int RLAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_val,
  input  logic              cmd_we,
  input  logic [31:0]       cmd_adr,
  input  logic [3:0]        cmd_sel,
  input  logic [31:0]       cmd_dat,
  output logic              rd_ack,
  output logic [31:0]       rd_dat,
  output logic              busy,
  output logic [2:0]        err,
  output logic [NRA-1:0]    ra_r0_enb,
  output logic [NRA-1:0]    ra_r1_enb,
  output logic [NRA*AW-1:0] ra_r0_adr,
  output logic [NRA*AW-1:0] ra_r1_adr,
  input  logic [NRA*DW-1:0] ra_r0_dat,
  input  logic [NRA*DW-1:0] ra_r1_dat,
  output logic [NRA-1:0]    ra_w0_enb,
  output logic [NRA*AW-1:0] ra_w0_adr,
  output logic [NRA*DW-1:0] ra_w0_dat
);

  localparam int NB       = DW / 8;
  localparam int IDX_LSB  = idx_lsb(AW);
  localparam int PORT_BIT = port_bit(AW);

  function automatic logic [31:0] zext_dw(input logic [DW-1:0] d);
    logic [31:0] r;
    r         = '0;
    r[DW-1:0] = d;
    return r;
  endfunction

  // Byte-lane merge for partial writes: selected lanes come from the command.
  function automatic logic [DW-1:0] rmw_merge(input logic [DW-1:0] old_w,
                                              input logic [31:0]   new_w,
                                              input logic [3:0]    sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              iss_q;
  logic              rd_strobe, wr_strobe, use_r1, smp;
  logic              port_q, skip_q;
  logic [AW-1:0]     word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [DW-1:0]     wdat_q;
  logic [31:0]       rd_dat_q;
  logic [ERR_W-1:0]  err_q;
  logic [DW-1:0]     rdat;

  logic [IDX_W-1:0]  new_idx;
  logic              new_bad, new_none, new_full, accept;
  logic              unused_adr;

  assign new_idx  = cmd_adr[IDX_LSB +: IDX_W];
  assign new_bad  = int'(new_idx) >= NRA;
  assign new_none = ~|cmd_sel[NB-1:0];
  assign new_full = &cmd_sel[NB-1:0];
  assign accept   = cmd_val && (state_q == S_IDLE);

  assign unused_adr = ^{cmd_adr[31:PORT_BIT+1], cmd_adr[WORD_LSB-1:0]};

  // Stage 0 -> 1: read strobe to data-sample strobe
  ra_rlat_pipe #(.RLAT(RLAT)) u_rlat_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_p0 (rd_strobe),
    .smp    (smp)
  );

  // Next state; rd_strobe fires only in the first cycle of a read state.
  always_comb begin
    state_d   = state_q;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_val) begin
          if (!cmd_we)                           state_d = S_RD;
          else if (new_bad || new_none || new_full) state_d = S_WR;
          else                                   state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        if (skip_q) begin
          state_d = S_ACK;
        end else begin
          rd_strobe = !iss_q;
          if (smp) state_d = S_ACK;
        end
      end
      S_RMW_RD: begin
        rd_strobe = !iss_q;
        if (smp) state_d = S_WR;
      end
      S_WR: begin
        wr_strobe = !skip_q;
`ifdef RA_READBACK_EN
        state_d   = skip_q ? S_ACK : S_RB;
`else
        state_d   = S_ACK;
`endif
      end
`ifdef RA_READBACK_EN
      S_RB: begin
        rd_strobe = !iss_q;
        if (smp) state_d = S_ACK;
      end
`endif
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    use_r1 = (state_q == S_RD) && port_q;
`ifdef RA_READBACK_EN
    use_r1 = use_r1 || (state_q == S_RB);
`endif
  end

  // Data returned by the addressed array on the port in use
  always_comb begin
    rdat = '0;
    for (int i = 0; i < NRA; i++) begin
      if (idx_q == IDX_W'(i)) rdat = use_r1 ? ra_r1_dat[i*DW +: DW] : ra_r0_dat[i*DW +: DW];
    end
  end

  // Array port drive; everything outside the strobe cycle stays 0.
  always_comb begin
    ra_r0_enb = '0;
    ra_r1_enb = '0;
    ra_r0_adr = '0;
    ra_r1_adr = '0;
    ra_w0_enb = '0;
    ra_w0_adr = '0;
    ra_w0_dat = '0;
    for (int i = 0; i < NRA; i++) begin
      if (idx_q == IDX_W'(i)) begin
        if (rd_strobe) begin
          if (use_r1) begin
            ra_r1_enb[i]           = 1'b1;
            ra_r1_adr[i*AW +: AW]  = word_q;
          end else begin
            ra_r0_enb[i]           = 1'b1;
            ra_r0_adr[i*AW +: AW]  = word_q;
          end
        end
        if (wr_strobe) begin
          ra_w0_enb[i]           = 1'b1;
          ra_w0_adr[i*AW +: AW]  = word_q;
          ra_w0_dat[i*DW +: DW]  = wdat_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      iss_q    <= 1'b0;
      err_q    <= '0;
      rd_dat_q <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= (state_d == state_q) && (iss_q || rd_strobe);
      if (cmd_val && (state_q != S_IDLE)) err_q[ERR_DROP] <= 1'b1;
      if (accept) begin
        if (new_bad) err_q[ERR_SEL] <= 1'b1;
        rd_dat_q <= (new_bad && !cmd_we) ? BAD_RD_DAT : '0;
      end
      if ((state_q == S_RD) && smp) rd_dat_q <= zext_dw(rdat);
`ifdef RA_READBACK_EN
      if ((state_q == S_RB) && smp && (rdat != wdat_q)) err_q[ERR_RB] <= 1'b1;
`endif
    end
  end

  // Command capture; only meaningful while the FSM is out of IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      port_q <= cmd_adr[PORT_BIT];
      word_q <= cmd_adr[WORD_LSB +: AW];
      idx_q  <= new_idx;
      sel_q  <= cmd_sel;
      dat_q  <= cmd_dat;
      skip_q <= new_bad || (cmd_we && new_none);
      wdat_q <= cmd_dat[DW-1:0];
    end else if ((state_q == S_RMW_RD) && smp) begin
      wdat_q <= rmw_merge(rdat, dat_q, sel_q);
    end
  end

  assign rd_ack = (state_q == S_ACK);
  assign busy   = (state_q != S_IDLE);
  assign rd_dat = rd_dat_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ra_site_ctl.sv
// ----------------------------------------------------------------------------
// tb_ra_site_ctl
// Directed bench for ra_site_ctl. Main instance (RLAT=1) talks to a small
// behavioural two-array model; a second instance (RLAT=3) shares the command
// bus and sees constant array read data.
// ----------------------------------------------------------------------------
module tb_ra_site_ctl;

  localparam int NRA = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;
`ifdef RA_READBACK_EN
  localparam int RBX = 2;
  localparam logic [2:0] ERR_AFTER_RB = 3'b111;
`else
  localparam int RBX = 0;
  localparam logic [2:0] ERR_AFTER_RB = 3'b011;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cmd_val, cmd_we;
  logic [31:0]       cmd_adr, cmd_dat;
  logic [3:0]        cmd_sel;

  logic              rd_ack, busy;
  logic [31:0]       rd_dat;
  logic [2:0]        err;
  logic [NRA-1:0]    ra_r0_enb, ra_r1_enb, ra_w0_enb;
  logic [NRA*AW-1:0] ra_r0_adr, ra_r1_adr, ra_w0_adr;
  logic [NRA*DW-1:0] ra_r0_dat, ra_r1_dat, ra_w0_dat;

  logic              rd_ack3, busy3;
  logic [31:0]       rd_dat3;
  logic [2:0]        err3;
  logic [NRA-1:0]    r0_enb3, r1_enb3, w0_enb3;
  logic [NRA*AW-1:0] r0_adr3, r1_adr3, w0_adr3;
  logic [NRA*DW-1:0] r0_dat3, r1_dat3, w0_dat3;

  assign r0_dat3 = {32'h0B0B_0B0B, 32'h0A0A_0A0A};
  assign r1_dat3 = {32'h5A5A_0001, 32'h5A5A_0000};

  ra_site_ctl #(.NRA(NRA), .AW(AW), .DW(DW), .RLAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rd_ack(rd_ack), .rd_dat(rd_dat), .busy(busy), .err(err),
    .ra_r0_enb(ra_r0_enb), .ra_r1_enb(ra_r1_enb), .ra_r0_adr(ra_r0_adr), .ra_r1_adr(ra_r1_adr),
    .ra_r0_dat(ra_r0_dat), .ra_r1_dat(ra_r1_dat),
    .ra_w0_enb(ra_w0_enb), .ra_w0_adr(ra_w0_adr), .ra_w0_dat(ra_w0_dat)
  );

  ra_site_ctl #(.NRA(NRA), .AW(AW), .DW(DW), .RLAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rd_ack(rd_ack3), .rd_dat(rd_dat3), .busy(busy3), .err(err3),
    .ra_r0_enb(r0_enb3), .ra_r1_enb(r1_enb3), .ra_r0_adr(r0_adr3), .ra_r1_adr(r1_adr3),
    .ra_r0_dat(r0_dat3), .ra_r1_dat(r1_dat3),
    .ra_w0_enb(w0_enb3), .ra_w0_adr(w0_adr3), .ra_w0_dat(w0_dat3)
  );

  // Behavioural arrays: one-cycle synchronous read, optional r1 bit-0 fault.
  logic [31:0] mem [0:1][0:31];
  logic [31:0] r0q [0:1];
  logic [31:0] r1q [0:1];
  logic        corrupt;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        r0q[i] <= '0;
        r1q[i] <= '0;
        for (int w = 0; w < 32; w++) mem[i][w] <= '0;
      end else begin
        if (ra_w0_enb[i]) mem[i][ra_w0_adr[i*AW +: AW]] <= ra_w0_dat[i*DW +: DW];
        if (ra_r0_enb[i]) r0q[i] <= mem[i][ra_r0_adr[i*AW +: AW]];
        if (ra_r1_enb[i]) r1q[i] <= mem[i][ra_r1_adr[i*AW +: AW]] ^ {31'b0, corrupt};
      end
    end
  end

  assign ra_r0_dat = {r0q[1], r0q[0]};
  assign ra_r1_dat = {r1q[1], r1q[0]};

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observations of the last command (cycle offsets relative to accept T)
  int              ack_at, n_ack, w_at, n_w, r0_at, n_r0, r1_at, ack3_at, r13_at;
  logic [31:0]     ack_dat, ack3_dat;
  logic [NRA-1:0]  w_enb, r0_v, r1_v, r13_v;
  logic [63:0]     w_dat;
  logic [9:0]      w_adr;
  logic            busy1;

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input bit hold2);
    ack_at = 0; n_ack = 0; w_at = 0; n_w = 0; r0_at = 0; n_r0 = 0; r1_at = 0;
    ack3_at = 0; r13_at = 0; ack_dat = '0; ack3_dat = '0;
    w_enb = '0; r0_v = '0; r1_v = '0; r13_v = '0; w_dat = '0; w_adr = '0; busy1 = 1'b0;
    @(negedge clk);
    cmd_val = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == (hold2 ? 2 : 1)) cmd_val = 1'b0;
      if (k == 1) busy1 = busy;
      if (rd_ack) begin
        n_ack++;
        if (ack_at == 0) begin ack_at = k; ack_dat = rd_dat; end
      end
      if (|ra_w0_enb) begin
        n_w++;
        if (w_at == 0) begin w_at = k; w_enb = ra_w0_enb; w_dat = ra_w0_dat; w_adr = ra_w0_adr; end
      end
      if (|ra_r0_enb) begin
        n_r0++;
        if (r0_at == 0) begin r0_at = k; r0_v = ra_r0_enb; end
      end
      if ((|ra_r1_enb) && r1_at == 0) begin r1_at = k; r1_v = ra_r1_enb; end
      if (rd_ack3 && ack3_at == 0) begin ack3_at = k; ack3_dat = rd_dat3; end
      if ((|r1_enb3) && r13_at == 0) begin r13_at = k; r13_v = r1_enb3; end
    end
  endtask

  int cnt_ack, cnt_acc;

  initial begin
    rst = 1'b1; cmd_val = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_dat = '0;
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", rd_ack, 0);
    check_eq("rst_rd_dat", rd_dat, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_enb", {ra_r0_enb, ra_r1_enb, ra_w0_enb}, 0);
    check_eq("rst_adr", {ra_r0_adr, ra_r1_adr, ra_w0_adr}, 0);
    rst = 1'b0;

    // Full write, word 3 of array 0
    run_cmd(1'b1, 32'h0000_000C, 4'hF, 32'hA5A5_A5A5, 1'b0);
    check_eq("fw_busy", busy1, 1);
    check_eq("fw_w_at", w_at, 1);
    check_eq("fw_w_enb", w_enb, 2'b01);
    check_eq("fw_w_dat", w_dat, {32'h0, 32'hA5A5_A5A5});
    check_eq("fw_w_adr", w_adr, 10'h003);
    check_eq("fw_ack_at", ack_at, 2 + RBX);
    check_eq("fw_ack_dat", ack_dat, 0);
    check_eq("fw_n_ack", n_ack, 1);

    // Read it back through r0
    run_cmd(1'b0, 32'h0000_000C, 4'hF, 32'h0, 1'b0);
    check_eq("rd_r0_at", r0_at, 1);
    check_eq("rd_r0_enb", r0_v, 2'b01);
    check_eq("rd_n_r0", n_r0, 1);
    check_eq("rd_r1_at", r1_at, 0);
    check_eq("rd_n_w", n_w, 0);
    check_eq("rd_ack_at", ack_at, 3);
    check_eq("rd_dat", ack_dat, 32'hA5A5_A5A5);

    // Partial write (lane 1) over 0x11223344
    run_cmd(1'b1, 32'h0000_000C, 4'hF, 32'h1122_3344, 1'b0);
    run_cmd(1'b1, 32'h0000_000C, 4'h2, 32'h0000_BB00, 1'b0);
    check_eq("pw_r0_at", r0_at, 1);
    check_eq("pw_w_at", w_at, 3);
    check_eq("pw_w_dat", w_dat, {32'h0, 32'h1122_BB44});
    check_eq("pw_ack_at", ack_at, 4 + RBX);

    // Read via r1 port (address bit 10)
    run_cmd(1'b0, 32'h0000_040C, 4'hF, 32'h0, 1'b0);
    check_eq("r1_at", r1_at, 1);
    check_eq("r1_enb", r1_v, 2'b01);
    check_eq("r1_r0_at", r0_at, 0);
    check_eq("r1_ack_at", ack_at, 3);
    check_eq("r1_dat", ack_dat, 32'h1122_BB44);

    // Array 1, word 5
    run_cmd(1'b1, 32'h0000_0094, 4'hF, 32'hDEAD_BEEF, 1'b0);
    check_eq("a1_w_enb", w_enb, 2'b10);
    check_eq("a1_w_dat", w_dat, {32'hDEAD_BEEF, 32'h0});
    check_eq("a1_w_adr", w_adr, 10'h0A0);
    run_cmd(1'b0, 32'h0000_0094, 4'hF, 32'h0, 1'b0);
    check_eq("a1_r0_enb", r0_v, 2'b10);
    check_eq("a1_rd_dat", ack_dat, 32'hDEAD_BEEF);

    // Write with no lanes selected
    run_cmd(1'b1, 32'h0000_000C, 4'h0, 32'hFFFF_FFFF, 1'b0);
    check_eq("sz_n_w", n_w, 0);
    check_eq("sz_r0_at", r0_at, 0);
    check_eq("sz_r1_at", r1_at, 0);
    check_eq("sz_ack_at", ack_at, 2);
    check_eq("sz_err", err, 3'b000);

    // Missing array (index 2)
    run_cmd(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b0);
    check_eq("bad_n_r0", n_r0, 0);
    check_eq("bad_r1_at", r1_at, 0);
    check_eq("bad_ack_at", ack_at, 2);
    check_eq("bad_rd_dat", ack_dat, 32'hFFFF_FFFF);
    check_eq("bad_err", err, 3'b001);

    // Command held for two cycles: second one is dropped
    run_cmd(1'b0, 32'h0000_000C, 4'hF, 32'h0, 1'b1);
    check_eq("drop_n_ack", n_ack, 1);
    check_eq("drop_ack_at", ack_at, 3);
    check_eq("drop_dat", ack_dat, 32'h1122_BB44);
    check_eq("drop_err", err, 3'b011);

    // RLAT=3 instance: r1 read of array 1
    run_cmd(1'b0, 32'h0000_0488, 4'hF, 32'h0, 1'b0);
    check_eq("l3_r1_at", r13_at, 1);
    check_eq("l3_r1_enb", r13_v, 2'b10);
    check_eq("l3_ack_at", ack3_at, 5);
    check_eq("l3_dat", ack3_dat, 32'h5A5A_0001);
    check_eq("l1_r1_enb", r1_v, 2'b10);

    // Write with faulty r1 readback
    corrupt = 1'b1;
    run_cmd(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 1'b0);
    corrupt = 1'b0;
    check_eq("rb_ack_at", ack_at, 2 + RBX);
    check_eq("rb_err", err, ERR_AFTER_RB);

    // Reset in the middle of a read
    @(negedge clk);
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_000C; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_val = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mr_busy", busy, 0);
    check_eq("mr_ack", rd_ack, 0);
    check_eq("mr_rd_dat", rd_dat, 0);
    check_eq("mr_err", err, 0);
    check_eq("mr_outs", {ra_r0_enb, ra_r1_enb, ra_w0_enb, ra_r0_adr, ra_r1_adr, ra_w0_adr}, 0);
    cnt_ack = 0; cnt_acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rd_ack) cnt_ack++;
      if (|{ra_r0_enb, ra_r1_enb, ra_w0_enb}) cnt_acc++;
    end
    check_eq("mr_no_ack", cnt_ack, 0);
    check_eq("mr_no_acc", cnt_acc, 0);

    // Reset while a partial write is waiting for its write cycle
    @(negedge clk);
    cmd_val = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_000C; cmd_sel = 4'h1; cmd_dat = 32'h0000_00EE;
    @(negedge clk);
    cmd_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mw_busy", busy, 0);
    check_eq("mw_w_enb", ra_w0_enb, 0);
    cnt_ack = 0; cnt_acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rd_ack) cnt_ack++;
      if (|ra_w0_enb) cnt_acc++;
    end
    check_eq("mw_no_ack", cnt_ack, 0);
    check_eq("mw_no_wr", cnt_acc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
